// File: rtl/micro_sequencer_if.sv
// Control/status bundle between the micro-sequencer and the 4-bit bus datapath.
// The slave modport is the sequencer's view; the master modport is the datapath/debugger side.
interface micro_sequencer_if #(
  parameter int N    = 4,
  parameter int PC_W = 3
);
  logic            StepEn;
  logic            Run;
  logic [3:0]      Opcode;
  logic [N-1:0]    Operand;
  logic            AluCarry;

  logic            LatchA;
  logic            EnableA;
  logic            LatchB;
  logic            EnableALU;
  logic            AddSub;
  logic            EnableIN;
  logic            EnableOut;
  logic            LoadInstr;
  logic            EnableInstr;
  logic            EnableCount;
  logic            LoadPC;
  logic [PC_W-1:0] PcLoadVal;
  logic            CarryFlag;
  logic            Halted;
  logic [2:0]      State;

  modport slave (
    input  StepEn, Run, Opcode, Operand, AluCarry,
    output LatchA, EnableA, LatchB, EnableALU, AddSub, EnableIN, EnableOut,
           LoadInstr, EnableInstr, EnableCount, LoadPC, PcLoadVal,
           CarryFlag, Halted, State
  );

  modport master (
    output StepEn, Run, Opcode, Operand, AluCarry,
    input  LatchA, EnableA, LatchB, EnableALU, AddSub, EnableIN, EnableOut,
           LoadInstr, EnableInstr, EnableCount, LoadPC, PcLoadVal,
           CarryFlag, Halted, State
  );
endinterface

// File: rtl/micro_sequencer.sv
// Fetch/decode/execute control FSM for the 4-bit bus machine: Moore strobes from state and
// opcode, a registered carry flag for JC, halt, and a StepEn clock enable on every register.
module micro_sequencer #(
  parameter int N    = 4,
  parameter int PC_W = 3
) (
  input  logic MainClock,
  input  logic MainReset_n,
  micro_sequencer_if.slave sif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_IN  = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_CLC = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t r_state;
  state_t w_state_next;
  logic   r_carry;
  logic   w_carry_next;
  // Remembers that EXEC1 loaded the PC so EXEC2 must not also increment it.
  logic   r_loaded;
  logic   w_loaded_next;

  logic w_latch_a;
  logic w_enable_a;
  logic w_latch_b;
  logic w_enable_alu;
  logic w_add_sub;
  logic w_enable_in;
  logic w_enable_out;
  logic w_load_instr;
  logic w_enable_instr;
  logic w_enable_count;
  logic w_load_pc;
  logic w_halted;
  logic [N-1:0] w_operand;

  assign w_operand = sif.Operand;

  always_ff @(posedge MainClock or negedge MainReset_n) begin
    if (!MainReset_n) begin
      r_state  <= S_IDLE;
      r_carry  <= 1'b0;
      r_loaded <= 1'b0;
    end else if (sif.StepEn) begin
      r_state  <= w_state_next;
      r_carry  <= w_carry_next;
      r_loaded <= w_loaded_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_carry_next   = r_carry;
    w_loaded_next  = r_loaded;
    w_latch_a      = 1'b0;
    w_enable_a     = 1'b0;
    w_latch_b      = 1'b0;
    w_enable_alu   = 1'b0;
    w_add_sub      = 1'b0;
    w_enable_in    = 1'b0;
    w_enable_out   = 1'b0;
    w_load_instr   = 1'b0;
    w_enable_instr = 1'b0;
    w_enable_count = 1'b0;
    w_load_pc      = 1'b0;
    w_halted       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (sif.Run) w_state_next = S_FETCH;
      end
      S_FETCH: begin
        w_load_instr = 1'b1;
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_state_next = (sif.Opcode == OP_HLT) ? S_HALT : S_EXEC1;
      end
      S_EXEC1: begin
        w_state_next  = S_EXEC2;
        w_loaded_next = 1'b0;
        // Each arm enables at most one bus driver; unlisted opcodes behave as NOP.
        case (sif.Opcode)
          OP_LDA: begin
            w_enable_instr = 1'b1;
            w_latch_a      = 1'b1;
          end
          OP_LDB: begin
            w_enable_instr = 1'b1;
            w_latch_b      = 1'b1;
          end
          OP_ADD: begin
            w_enable_alu = 1'b1;
            w_latch_a    = 1'b1;
            w_carry_next = sif.AluCarry;
          end
          OP_SUB: begin
            w_enable_alu = 1'b1;
            w_add_sub    = 1'b1;
            w_latch_a    = 1'b1;
            w_carry_next = sif.AluCarry;
          end
          OP_OUT: begin
            w_enable_a   = 1'b1;
            w_enable_out = 1'b1;
          end
          OP_IN: begin
            w_enable_in = 1'b1;
            w_latch_a   = 1'b1;
          end
          OP_JMP: begin
            w_load_pc     = 1'b1;
            w_loaded_next = 1'b1;
          end
          OP_JC: begin
            w_load_pc     = r_carry;
            w_loaded_next = r_carry;
          end
          OP_CLC: begin
            w_carry_next = 1'b0;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        w_enable_count = !r_loaded;
        w_state_next   = sif.Run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign sif.LatchA      = w_latch_a;
  assign sif.EnableA     = w_enable_a;
  assign sif.LatchB      = w_latch_b;
  assign sif.EnableALU   = w_enable_alu;
  assign sif.AddSub      = w_add_sub;
  assign sif.EnableIN    = w_enable_in;
  assign sif.EnableOut   = w_enable_out;
  assign sif.LoadInstr   = w_load_instr;
  assign sif.EnableInstr = w_enable_instr;
  assign sif.EnableCount = w_enable_count;
  assign sif.LoadPC      = w_load_pc;
  assign sif.PcLoadVal   = w_load_pc ? w_operand[PC_W-1:0] : '0;
  assign sif.CarryFlag   = r_carry;
  assign sif.Halted      = w_halted;
  assign sif.State       = r_state;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: a small ROM/PC/IR/A/B/ALU datapath model closes the loop, an
// opcode table checks every instruction's strobes, and hand sequences cover the multi-cycle cases.
module tb_micro_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic step_en = 1'b0;
  logic run     = 1'b0;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  micro_sequencer_if #(.N(4), .PC_W(3)) sif ();

  micro_sequencer #(.N(4), .PC_W(3)) dut (
    .MainClock   (clk),
    .MainReset_n (rst_n),
    .sif         (sif.slave)
  );

  always #5 clk = ~clk;

  // Datapath model
  localparam logic [3:0] IN_VAL = 4'hC;
  logic [7:0] rom [8];
  logic [2:0] pc;
  logic [7:0] ir;
  logic [3:0] a_reg, b_reg, out_reg;
  logic [4:0] alu;
  logic [3:0] bus_val;
  logic [10:0] strobes;

  assign sif.StepEn   = step_en;
  assign sif.Run      = run;
  assign sif.Opcode   = ir[7:4];
  assign sif.Operand  = ir[3:0];
  assign sif.AluCarry = alu[4];

  assign strobes = {sif.LatchA, sif.EnableA, sif.LatchB, sif.EnableALU, sif.AddSub,
                    sif.EnableIN, sif.EnableOut, sif.LoadInstr, sif.EnableInstr,
                    sif.EnableCount, sif.LoadPC};

  always_comb begin
    alu = sif.AddSub ? ({1'b0, a_reg} - {1'b0, b_reg}) : ({1'b0, a_reg} + {1'b0, b_reg});
    bus_val = 4'h0;
    if (sif.EnableA)          bus_val = a_reg;
    else if (sif.EnableALU)   bus_val = alu[3:0];
    else if (sif.EnableIN)    bus_val = IN_VAL;
    else if (sif.EnableInstr) bus_val = ir[3:0];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0; ir <= '0; a_reg <= '0; b_reg <= '0; out_reg <= '0;
    end else if (step_en) begin
      if (sif.LoadInstr) ir <= rom[pc];
      if (sif.LoadPC) pc <= sif.PcLoadVal;
      else if (sif.EnableCount) pc <= pc + 3'd1;
      if (sif.LatchA) a_reg <= bus_val;
      if (sif.LatchB) b_reg <= bus_val;
      if (sif.EnableOut) out_reg <= bus_val;
    end
  end

  always @(negedge clk) begin
    if (rst_n && (($countones({sif.EnableA, sif.EnableALU, sif.EnableIN, sif.EnableInstr}) > 1) ||
                  (sif.LoadPC && sif.EnableCount))) begin
      viol <= viol + 1;
      $display("FAIL bus_monitor: state=%0d strobes=%b", sif.State, strobes);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_prog(input logic [63:0] p);
    for (int i = 0; i < 8; i++) rom[i] = p[i*8 +: 8];
  endtask

  task automatic do_reset();
    run = 1'b0;
    step_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    step_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Strobe vector bit order: LatchA EnableA LatchB EnableALU AddSub EnableIN EnableOut
  // LoadInstr EnableInstr EnableCount LoadPC.
  typedef struct {
    logic [3:0]  op;
    logic [3:0]  operand;
    logic [2:0]  exp_state1;
    logic [10:0] exp_ex1;
    logic [2:0]  exp_pcl;
    logic [2:0]  exp_state2;
    logic [10:0] exp_ex2;
  } vec_t;

  vec_t vecs [16];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ec_count;
    int seen_out;
    logic [2:0]  exp_st;
    logic [10:0] snap;
    logic [2:0]  seq [4];

    for (int i = 0; i < 16; i++) begin
      vecs[i].op         = 4'(i);
      vecs[i].operand    = 4'hD;
      vecs[i].exp_state1 = 3'd3;
      vecs[i].exp_ex1    = 11'b000_0000_0000;
      vecs[i].exp_pcl    = 3'd0;
      vecs[i].exp_state2 = 3'd4;
      vecs[i].exp_ex2    = 11'b000_0000_0010;
    end
    vecs[1].exp_ex1  = 11'b100_0000_0100;
    vecs[2].exp_ex1  = 11'b001_0000_0100;
    vecs[3].exp_ex1  = 11'b100_1000_0000;
    vecs[4].exp_ex1  = 11'b100_1100_0000;
    vecs[5].exp_ex1  = 11'b010_0001_0000;
    vecs[6].exp_ex1  = 11'b100_0010_0000;
    vecs[7].exp_ex1  = 11'b000_0000_0001;
    vecs[7].exp_pcl  = 3'd5;
    vecs[7].exp_ex2  = 11'b000_0000_0000;
    vecs[15].exp_state1 = 3'd5;
    vecs[15].exp_state2 = 3'd5;
    vecs[15].exp_ex2    = 11'b000_0000_0000;

    // Reset state
    set_prog(64'h0);
    rst_n = 1'b0;
    #3;
    chk("reset_state", 32'(sif.State), 32'd0);
    chk("reset_strobes", 32'(strobes), 32'd0);
    chk("reset_flags", 32'({sif.CarryFlag, sif.Halted, sif.PcLoadVal}), 32'd0);

    // Opcode table: each instruction alone at ROM[0] after a reset
    for (int v = 0; v < 16; v++) begin
      do_reset();
      set_prog({56'h0, vecs[v].op, vecs[v].operand});
      run = 1'b1;
      step(); step(); step();
      chk($sformatf("op%h_exec1_state", vecs[v].op), 32'(sif.State), 32'(vecs[v].exp_state1));
      chk($sformatf("op%h_exec1_strobes", vecs[v].op), 32'(strobes), 32'(vecs[v].exp_ex1));
      chk($sformatf("op%h_pcloadval", vecs[v].op), 32'(sif.PcLoadVal), 32'(vecs[v].exp_pcl));
      step();
      chk($sformatf("op%h_exec2_state", vecs[v].op), 32'(sif.State), 32'(vecs[v].exp_state2));
      chk($sformatf("op%h_exec2_strobes", vecs[v].op), 32'(strobes), 32'(vecs[v].exp_ex2));
      $display("vector op=%h state=%0d strobes=%b", vecs[v].op, sif.State, strobes);
    end

    // LDA 5, LDB 3, ADD, OUT, HLT
    do_reset();
    set_prog(64'h0000_00F0_5030_2315);
    run = 1'b1;
    step();
    ec_count = 0;
    seen_out = 0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (sif.State == 3'd3 && sif.Opcode == 4'h5) begin
        seen_out = 1;
        chk("prog1_out_strobes", 32'({sif.EnableA, sif.EnableOut}), 32'b11);
        chk("prog1_out_bus", 32'(bus_val), 32'd8);
        chk("prog1_out_carry", 32'(sif.CarryFlag), 32'd0);
      end
      if (sif.EnableCount) ec_count++;
      if (k == 17) chk("prog1_not_halted_17", 32'(sif.Halted), 32'd0);
      if (k == 18) chk("prog1_halted_18", 32'(sif.Halted), 32'd1);
    end
    chk("prog1_out_seen", 32'(seen_out), 32'd1);
    chk("prog1_enable_count_pulses", 32'(ec_count), 32'd4);
    chk("prog1_out_reg", 32'(out_reg), 32'd8);
    step(); step();
    chk("prog1_halt_sticky", 32'({sif.State, sif.Halted, strobes}), {17'd0, 3'd5, 1'b1, 11'd0});
    $display("program1 done halted=%0d pulses=%0d out=%0d", sif.Halted, ec_count, out_reg);

    // LDA 9, LDB 9, ADD, JC 6 (taken) ... 6: CLC, 7: JC 3 (not taken)
    do_reset();
    set_prog(64'h8390_0000_8630_2919);
    run = 1'b1;
    step();
    repeat (12) step();
    chk("jc_carry_after_add", 32'(sif.CarryFlag), 32'd1);
    chk("jc_a_after_add", 32'(a_reg), 32'd2);
    step(); step();
    chk("jc_taken_loadpc", 32'({sif.LoadPC, sif.PcLoadVal}), {28'd0, 1'b1, 3'd6});
    step();
    chk("jc_taken_exec2", 32'({sif.EnableCount, sif.LoadPC}), 32'b00);
    step();
    chk("jc_taken_pc", 32'(pc), 32'd6);
    repeat (4) step();
    chk("clc_carry", 32'(sif.CarryFlag), 32'd0);
    step(); step();
    chk("jc_not_taken_loadpc", 32'({sif.LoadPC, sif.PcLoadVal}), 32'd0);
    run = 1'b0;
    step();
    chk("jc_not_taken_exec2", 32'({sif.EnableCount, sif.LoadPC}), 32'b10);
    step();
    chk("jc_not_taken_pc_wrap", 32'({sif.State, pc}), 32'd0);
    $display("jc sequence done");

    // Reset in EXEC1 of an ADD while carry is set
    do_reset();
    set_prog(64'h0000_0000_3030_2919);
    run = 1'b1;
    step();
    repeat (12) step();
    step(); step();
    chk("rst_mid_pre", 32'({sif.State, sif.LatchA, sif.CarryFlag}), {27'd0, 3'd3, 1'b1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_state", 32'(sif.State), 32'd0);
    chk("rst_mid_strobes", 32'(strobes), 32'd0);
    chk("rst_mid_carry", 32'(sif.CarryFlag), 32'd0);
    #3 rst_n = 1'b1;
    $display("mid-instruction reset done");

    // StepEn 1-of-4 during one instruction
    do_reset();
    set_prog(64'h0000_00F0_5030_2315);
    run = 1'b1;
    step();
    seq[0] = 3'd2; seq[1] = 3'd3; seq[2] = 3'd4; seq[3] = 3'd1;
    exp_st = 3'd1;
    snap = strobes;
    for (int c = 0; c < 16; c++) begin
      step_en = (c % 4 == 0);
      @(posedge clk);
      #1;
      if (c % 4 == 0) begin
        exp_st = seq[c / 4];
        snap = strobes;
      end else begin
        chk($sformatf("stepen_hold_strobes_c%0d", c), 32'(strobes), 32'(snap));
      end
      chk($sformatf("stepen_state_c%0d", c), 32'(sif.State), 32'(exp_st));
    end
    chk("stepen_a_loaded", 32'(a_reg), 32'd5);
    $display("step-enable sequence done");

    // Run dropped during DECODE, then reasserted
    do_reset();
    set_prog(64'h0000_00F0_5030_2315);
    run = 1'b1;
    step(); step();
    chk("run_decode_state", 32'(sif.State), 32'd2);
    run = 1'b0;
    step(); step();
    chk("run_exec2_state", 32'(sif.State), 32'd4);
    step();
    chk("run_idle_state", 32'({sif.State, strobes}), 32'd0);
    step();
    chk("run_idle_holds", 32'(sif.State), 32'd0);
    run = 1'b1;
    step_en = 1'b0;
    @(posedge clk);
    #1;
    chk("run_disabled_holds", 32'(sif.State), 32'd0);
    step();
    chk("run_refetch", 32'({sif.State, sif.LoadInstr}), {28'd0, 3'd1, 1'b1});
    $display("run sequence done a=%0d", a_reg);

    @(negedge clk);
    chk("bus_monitor_violations", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Control FSM that sequences the 4-bit bus datapath (Accumulator A/B, ALU, In/Out registers, Instruction Register, Program Counter + 8-entry ROM) through fetch/decode/execute.
- Decodes the 4-bit opcode from the Instruction Register and drives all latch/enable strobes with guaranteed single-driver bus access.
- Adds conditional jump on a registered carry flag, halt, and single-step gating.

Parameters:
- N, 4, datapath/bus width
- PC_W, 3, program counter width (ROM depth 2^PC_W)

Ports:
- MainClock  in  1  system clock, rising edge
- MainReset_n  in  1  asynchronous active-low reset
- StepEn  in  1  clock enable; FSM advances only on cycles with StepEn=1
- Run  in  1  1 = leave IDLE and execute; 0 = hold in IDLE
- Opcode  in  4  instruction field from Instruction Register
- Operand  in  N  data field from Instruction Register
- AluCarry  in  1  ALU carry/borrow out, combinational
- LatchA, EnableA, LatchB, EnableALU, AddSub, EnableIN, EnableOut, LoadInstr, EnableInstr  out  1 each  datapath strobes
- EnableCount  out  1  PC increment
- LoadPC  out  1  PC parallel load
- PcLoadVal  out  PC_W  jump target (Operand[PC_W-1:0])
- CarryFlag  out  1  registered carry
- Halted  out  1  high in HALT state
- State  out  3  current state encoding, for the debugger

Behaviour:
- Reset (MainReset_n=0, async): State=IDLE, CarryFlag=0, Halted=0, all strobes 0, PcLoadVal=0. Reset mid-instruction aborts immediately with no partial strobe.
- All state and flag updates require StepEn=1. With StepEn=0, state, flags, and outputs hold.
- Strobes are Moore outputs decoded from State and Opcode. Exactly zero or one bus driver (EnableA, EnableALU, EnableIN, EnableInstr) is high in any state.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC1=3, EXEC2=4, HALT=5.
- IDLE: all outputs 0. Goes to FETCH when Run=1.
- FETCH: LoadInstr=1. Goes to DECODE.
- DECODE: no strobes. Goes to EXEC1 unless Opcode=F (goes to HALT).
- EXEC1, by opcode:
  - 0 NOP: no strobes.
  - 1 LDA: EnableInstr, LatchA.
  - 2 LDB: EnableInstr, LatchB.
  - 3 ADD: EnableALU, AddSub=0, LatchA; CarryFlag<=AluCarry.
  - 4 SUB: EnableALU, AddSub=1, LatchA; CarryFlag<=AluCarry.
  - 5 OUT: EnableA, EnableOut.
  - 6 IN: EnableIN, LatchA.
  - 7 JMP: LoadPC.
  - 8 JC: LoadPC only if CarryFlag=1.
  - 9 CLC: CarryFlag<=0.
  - A–E: treated as NOP.
- EXEC1 always goes to EXEC2.
- EXEC2: EnableCount=1 unless a load occurred in EXEC1 (JMP, or JC taken). Then goes to FETCH if Run=1, else IDLE.
- PC wrap: 7→0 is handled by the counter; the sequencer does no special handling.
- HALT: Halted=1, no strobes. Left only by reset. Run is ignored in HALT.
- Simultaneous LoadPC and EnableCount is forbidden and never occurs.
- Instruction latency: 4 enabled clocks (FETCH, DECODE, EXEC1, EXEC2).

Test Plan:
- Reset while in EXEC1 of ADD (LatchA=1) with StepEn=1 → State=0, all strobes 0 immediately; CarryFlag=0.
- Program LDA 5, LDB 3, ADD, OUT, HLT with Run=1 → OUT cycle shows EnableA=EnableOut=1 with A=8, CarryFlag=0; Halted=1 after 18 enabled clocks; EnableCount pulsed 4 times.
- LDA 9, LDB 9, ADD → CarryFlag=1. Next JC 6 → LoadPC=1, PcLoadVal=6, EnableCount=0 in EXEC2. With CarryFlag=0, the same JC gives LoadPC=0 and EnableCount=1.
- StepEn toggled 1-of-4 during an instruction → state advances exactly once per enabled clock; outputs are stable across disabled cycles.
- Every state/opcode combination (0..F) checked by assertion → at most one of EnableA/EnableALU/EnableIN/EnableInstr high; LoadPC and EnableCount never both high.
- Run deasserted during DECODE → instruction completes, then State=IDLE; Run reasserted → FETCH on the next enabled clock.
